mmio_fifo_ctrl: RTL and testbench

//   Owns a host-fed FIFO reached over CCI-P MMIO and arbitrates it between the host (push/peek/status/control)
//   and an AFU-side consumer (valid/ready pop). Sits behind the AFU MMIO decode: consumes decoded c0 MMIO

---
 rtl/mmio_fifo_ctrl.sv | 95 +++++++++
 tb/tb_mmio_fifo_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: host-fed MMIO FIFO with AFU-side valid/ready pop; optional MMIO_FIFO_CTRL_HWM_EN adds a high-water-mark register
module mmio_fifo_ctrl #(
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmio_wr_valid,
    input  logic              mmio_rd_valid,
    input  logic [15:0]       mmio_addr,
    input  logic [8:0]        mmio_tid,
    input  logic [DATA_W-1:0] mmio_wr_data,
    output logic              rsp_valid,
    output logic [8:0]        rsp_tid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              deq_valid,
    output logic [DATA_W-1:0] deq_data,
    input  logic              deq_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic              ovf, udf, full, empty;
    logic              push_req, push, pop, ctrl_wr, flush, clr_err;
    logic [DATA_W-1:0] hwm_rd, rd_data;
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign deq_valid = !empty;
    assign deq_data  = empty ? '0 : mem[rd_ptr];
    assign pop       = deq_valid && deq_ready;
    assign push_req  = mmio_wr_valid && mmio_addr == BASE_ADDR;
    assign push      = push_req && (!full || pop);
    assign ctrl_wr   = mmio_wr_valid && mmio_addr == BASE_ADDR + 16'd4;
    assign flush     = ctrl_wr && mmio_wr_data[0];
    assign clr_err   = ctrl_wr && mmio_wr_data[1];
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign rd_data   = (mmio_addr == BASE_ADDR)          ? deq_data :
                       (mmio_addr == BASE_ADDR + 16'd2)  ? DATA_W'({udf, ovf, full, empty, 16'(count)}) :
                       (mmio_addr == BASE_ADDR + 16'd6)  ? hwm_rd : '0;
    // Storage write on an accepted push; contents need no reset since empty masks deq_data
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= mmio_wr_data;
    end
    // Pointers, occupancy and sticky error flags; flush overrides any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
            ovf <= (ovf && !clr_err) || (push_req && !push);
            udf <= (udf && !clr_err) || (mmio_rd_valid && mmio_addr == BASE_ADDR && empty);
        end
    end
`ifdef MMIO_FIFO_CTRL_HWM_EN
    logic [CW-1:0] hwm;
    assign hwm_rd = DATA_W'(hwm);
    // Peak occupancy tracker; bounded by DEPTH because count is
    always_ff @(posedge clk) begin
        if (rst) hwm <= '0;
        else if (ctrl_wr && mmio_wr_data[2]) hwm <= count;
        else if (!flush && count_nxt > hwm) hwm <= count_nxt;
    end
`else
    assign hwm_rd = '0;
`endif
    // One-cycle read response from pre-update state; data/tid hold between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                rsp_tid  <= mmio_tid;
                rsp_data <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb_mmio_fifo_ctrl: directed and randomized checks of mmio_fifo_ctrl against a queue-based model
module tb_mmio_fifo_ctrl;
    localparam logic [15:0] BASE = 16'h0020;
    localparam logic [15:0] STAT = BASE + 16'd2;
    localparam logic [15:0] CTRL = BASE + 16'd4;
    localparam logic [15:0] HWMA = BASE + 16'd6;
`ifdef MMIO_FIFO_CTRL_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif
    logic        clk = 0, rst = 1;
    logic        mmio_wr_valid = 0, mmio_rd_valid = 0, deq_ready = 0;
    logic [15:0] mmio_addr = 0;
    logic [8:0]  mmio_tid = 0;
    logic [63:0] mmio_wr_data = 0;
    logic        rsp_valid, deq_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data, deq_data;
    int n_checks = 0, n_fail = 0;
    logic [63:0] q[$];
    logic        m_ovf, m_udf, m_rv;
    logic [8:0]  m_tid;
    logic [63:0] m_rd;
    int          m_hwm;

    mmio_fifo_ctrl dut (
        .clk(clk), .rst(rst), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model by the documented rules, sample 1 time unit after the edge
    task automatic cycle(input logic rs, input logic w, input logic r, input logic [15:0] a,
                         input logic [8:0] t, input logic [63:0] d, input logic rdy);
        int cnt;
        bit emp, ful, pop, acc, ctrl;
        logic [63:0] rv;
        rst = rs; mmio_wr_valid = w; mmio_rd_valid = r; mmio_addr = a;
        mmio_tid = t; mmio_wr_data = d; deq_ready = rdy;
        cnt = q.size(); emp = cnt == 0; ful = cnt == 16;
        if (rs) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_rv = 0; m_tid = 0; m_rd = 0; m_hwm = 0;
        end else begin
            rv = 0;
            if (a == BASE) rv = emp ? 64'd0 : q[0];
            else if (a == STAT) rv = {44'd0, m_udf, m_ovf, ful, emp, 16'(cnt)};
            else if (a == HWMA) rv = HWM_ON ? 64'(m_hwm) : 64'd0;
            m_rv = r;
            if (r) begin m_tid = t; m_rd = rv; end
            pop = !emp && rdy;
            acc = w && a == BASE && (!ful || pop);
            ctrl = w && a == CTRL;
            m_ovf = (m_ovf && !(ctrl && d[1])) || (w && a == BASE && !acc);
            m_udf = (m_udf && !(ctrl && d[1])) || (r && a == BASE && emp);
            if (ctrl && d[0]) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
            if (ctrl && d[2]) m_hwm = cnt;
            else if (q.size() > m_hwm) m_hwm = q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(0, 0, 0, 16'h0, 9'h0, 64'h0, rdy);
    endtask

    task automatic test_reset;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (rsp_valid !== 1'b0 || deq_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valids rsp_valid=%b deq_valid=%b want 0 0", rsp_valid, deq_valid); end
        n_checks++; if (rsp_tid !== 9'd0 || rsp_data !== 64'd0 || deq_data !== 64'd0) begin n_fail++;
            $display("FAIL reset_data tid=%0d rsp=%h deq=%h want 0", rsp_tid, rsp_data, deq_data); end
        cycle(0, 0, 1, STAT, 9'd5, 0, 0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'd5 || rsp_data !== 64'h10000) begin n_fail++;
            $display("FAIL reset_status v=%b tid=%0d data=%h want 1 5 10000", rsp_valid, rsp_tid, rsp_data); end
        idle(0);
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 64'h10000) begin n_fail++;
            $display("FAIL rsp_hold v=%b data=%h want 0 10000", rsp_valid, rsp_data); end
    endtask

    task automatic test_push_pop;
        logic [63:0] exp [3];
        exp[0] = 64'hA; exp[1] = 64'hB; exp[2] = 64'hC;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, BASE, 0, exp[i], 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (deq_valid !== 1'b1 || deq_data !== exp[i]) begin n_fail++;
                $display("FAIL pop_order[%0d] v=%b data=%h want 1 %h", i, deq_valid, deq_data, exp[i]); end
            idle(1);
        end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++;
            $display("FAIL pop_drained deq_valid=%b want 0", deq_valid); end
    endtask

    task automatic test_overflow_full;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, BASE, 0, 64'(i), 0);
        cycle(0, 0, 1, STAT, 9'd1, 0, 0);
        n_checks++; if (rsp_data !== 64'h60010) begin n_fail++;
            $display("FAIL ovf_status got %h want 60010", rsp_data); end
        cycle(0, 1, 0, CTRL, 0, 64'h2, 0);
        cycle(0, 0, 1, STAT, 9'd2, 0, 0);
        n_checks++; if (rsp_data !== 64'h20010) begin n_fail++;
            $display("FAIL ovf_clear got %h want 20010", rsp_data); end
        cycle(0, 1, 0, BASE, 0, 64'h55, 1);
        cycle(0, 0, 1, STAT, 9'd3, 0, 0);
        n_checks++; if (rsp_data !== 64'h20010) begin n_fail++;
            $display("FAIL full_pushpop_status got %h want 20010", rsp_data); end
        for (int i = 1; i <= 16; i++) begin
            n_checks++; if (deq_data !== (i == 16 ? 64'h55 : 64'(i))) begin n_fail++;
                $display("FAIL full_drain[%0d] got %h want %h", i, deq_data, (i == 16 ? 64'h55 : 64'(i))); end
            idle(1);
        end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++;
            $display("FAIL full_drained deq_valid=%b want 0", deq_valid); end
    endtask

    task automatic test_underflow_flush;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, BASE, 9'd3, 0, 0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'd3 || rsp_data !== 64'd0) begin n_fail++;
            $display("FAIL udf_peek v=%b tid=%0d data=%h want 1 3 0", rsp_valid, rsp_tid, rsp_data); end
        cycle(0, 0, 1, STAT, 9'd4, 0, 0);
        n_checks++; if (rsp_data !== 64'h90000) begin n_fail++;
            $display("FAIL udf_status got %h want 90000", rsp_data); end
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, BASE, 0, 64'(100 + i), 0);
        cycle(0, 1, 0, CTRL, 0, 64'h1, 1);
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_valid deq_valid=%b want 0", deq_valid); end
        cycle(0, 0, 1, STAT, 9'd6, 0, 0);
        n_checks++; if (rsp_data !== 64'h90000) begin n_fail++;
            $display("FAIL flush_status got %h want 90000", rsp_data); end
    endtask

    task automatic test_hwm;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, BASE, 0, 64'(i), 0);
        for (int i = 0; i < 3; i++) idle(1);
        cycle(0, 0, 1, HWMA, 9'd7, 0, 0);
        n_checks++; if (rsp_data !== (HWM_ON ? 64'd5 : 64'd0)) begin n_fail++;
            $display("FAIL hwm_peak got %h want %h", rsp_data, (HWM_ON ? 64'd5 : 64'd0)); end
        cycle(0, 1, 0, CTRL, 0, 64'h4, 0);
        cycle(0, 0, 1, HWMA, 9'd8, 0, 0);
        n_checks++; if (rsp_data !== (HWM_ON ? 64'd2 : 64'd0)) begin n_fail++;
            $display("FAIL hwm_clear got %h want %h", rsp_data, (HWM_ON ? 64'd2 : 64'd0)); end
    endtask

    task automatic test_random;
        logic [15:0] addrs [6];
        logic [15:0] a;
        logic [63:0] d;
        bit rs, w, r, rdy;
        addrs[0] = BASE; addrs[1] = BASE; addrs[2] = STAT; addrs[3] = CTRL; addrs[4] = HWMA; addrs[5] = BASE + 16'd8;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            a = addrs[$urandom_range(5)];
            if (a == BASE && $urandom_range(1)) a = BASE;
            d = {$urandom, $urandom};
            if (a == CTRL) d[0] = ($urandom_range(15) == 0);
            w = $urandom_range(2) != 0;
            r = $urandom_range(1);
            rdy = $urandom_range(3) < (((i / 200) % 2) ? 3 : 1);
            rs = $urandom_range(499) == 0;
            cycle(rs, w, r, a, 9'($urandom), d, rdy);
            n_checks++; if (rsp_valid !== m_rv || rsp_tid !== m_tid || rsp_data !== m_rd) begin n_fail++;
                $display("FAIL rand_rsp[%0d] v=%b tid=%0d data=%h want %b %0d %h",
                         i, rsp_valid, rsp_tid, rsp_data, m_rv, m_tid, m_rd); end
            n_checks++; if (deq_valid !== (q.size() != 0) || (q.size() != 0 && deq_data !== q[0])) begin n_fail++;
                $display("FAIL rand_deq[%0d] v=%b data=%h want %b %h", i, deq_valid, deq_data,
                         q.size() != 0, q.size() != 0 ? q[0] : 64'd0); end
        end
    endtask

    initial begin
        test_reset;
        test_push_pop;
        test_overflow_full;
        test_underflow_flush;
        test_hwm;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
